// File: rtl/password_lock_ctrl_pkg.sv
// Shared types and constants for the password lock controller.
//   state_e    : FSM state encoding
//   SEG_DASH   : active-low abcdefg glyph for '-' (only segment g lit)
//   SEG_BLANK  : active-low abcdefg with every segment off
//   max3/cnt_w : helpers for sizing the shared cycle timer
package password_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT,
    ST_PROG
  } state_e;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width able to hold 0..v, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/password_lock_ctrl_seg7_decoder.sv
// seg7_decoder: one hex digit to a 7-segment glyph.
//   digit_i : DIGIT_W-bit digit value
//   seg_o   : active-low segments, abcdefg order (a in bit 6)
// Values 10..15 show as A,b,C,d,E,F; anything wider than a nibble shows '-'.
module seg7_decoder
  import password_lock_ctrl_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [6:0]         seg_o
);

  localparam int WX = (DIGIT_W < 4) ? 4 : DIGIT_W;

  logic [WX-1:0] val;
  logic          hi;

  assign val = WX'(digit_i);

  if (WX > 4) begin : g_hi
    assign hi = |val[WX-1:4];
  end else begin : g_nohi
    assign hi = 1'b0;
  end

  always_comb begin
    seg_o = SEG_DASH;
    if (!hi) begin
      case (val[3:0])
        4'h0: seg_o = 7'b0000001;
        4'h1: seg_o = 7'b1001111;
        4'h2: seg_o = 7'b0010010;
        4'h3: seg_o = 7'b0000110;
        4'h4: seg_o = 7'b1001100;
        4'h5: seg_o = 7'b0100100;
        4'h6: seg_o = 7'b0100000;
        4'h7: seg_o = 7'b0001111;
        4'h8: seg_o = 7'b0000000;
        4'h9: seg_o = 7'b0000100;
        4'hA: seg_o = 7'b0001000;
        4'hB: seg_o = 7'b1100000;
        4'hC: seg_o = 7'b0110001;
        4'hD: seg_o = 7'b1000010;
        4'hE: seg_o = 7'b0110000;
        4'hF: seg_o = 7'b0111000;
      endcase
    end
  end

endmodule

// File: rtl/password_lock_ctrl.sv
// password_lock_ctrl: keypad-style code lock driven by one enter button.
//   clk        : block clock
//   rst        : asynchronous active-low reset
//   next       : enter button level (rising edge = press)
//   prog       : program request, sampled on a press while OPEN
//   digit_in   : digit on the switches
//   unlocked   : high in OPEN and PROG
//   alarm      : high in LOCKOUT
//   tries_left : remaining attempts
//   digit_cnt  : digits captured in the current entry
//   hex_out    : active-low glyphs, 7 bits per digit, digit 0 in the MS field
module password_lock_ctrl
  import password_lock_ctrl_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DIGIT_W     = 4,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES   = 3,
  parameter int FAIL_CYCLES = 10,
  parameter int LOCK_CYCLES = 50,
  parameter int OPEN_CYCLES = 100
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                next,
  input  logic                                prog,
  input  logic [DIGIT_W-1:0]                  digit_in,
  output logic                                unlocked,
  output logic                                alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left,
  output logic [$clog2(N_DIGITS+1)-1:0]       digit_cnt,
  output logic [N_DIGITS*7-1:0]               hex_out
);

  localparam int CODE_W = N_DIGITS * DIGIT_W;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int CNT_W  = $clog2(N_DIGITS + 1);
  localparam int T_W    = cnt_w(max3(FAIL_CYCLES, LOCK_CYCLES, OPEN_CYCLES));

  // Timer counts down to 0 inclusive, so a hold of C cycles loads C-1.
  localparam logic [T_W-1:0] FAIL_LD = T_W'((FAIL_CYCLES > 0) ? FAIL_CYCLES - 1 : 0);
  localparam logic [T_W-1:0] LOCK_LD = T_W'((LOCK_CYCLES > 0) ? LOCK_CYCLES - 1 : 0);
  localparam logic [T_W-1:0] OPEN_LD = T_W'((OPEN_CYCLES > 0) ? OPEN_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic                next_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   entry_q, entry_d, entry_wr;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [T_W-1:0]      timer_q, timer_d;
  logic                press;

  logic [N_DIGITS-1:0][6:0] glyph;

  assign press = next & ~next_q;

  // Entry with digit_in dropped into the slot addressed by cnt_q.
  always_comb begin
    entry_wr = entry_q;
    for (int i = 0; i < N_DIGITS; i++)
      if (cnt_q == CNT_W'(i)) entry_wr[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
  end

  // State register. next_q resets high so a button already held at
  // reset release is not seen as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      next_q  <= 1'b1;
      cnt_q   <= '0;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      tries_q <= TRY_W'(MAX_TRIES);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      next_q  <= next;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    code_d  = code_q;
    tries_d = tries_q;
    timer_d = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          entry_d = entry_wr;
          cnt_d   = CNT_W'(1);
          state_d = (N_DIGITS == 1) ? ST_CHECK : ST_ENTER;
        end
      end
      ST_ENTER: begin
        // A full entry sits one cycle before the compare.
        if (cnt_q == CNT_W'(N_DIGITS)) begin
          state_d = ST_CHECK;
        end else if (press) begin
          entry_d = entry_wr;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (entry_q == code_q) begin
          tries_d = TRY_W'(MAX_TRIES);
          state_d = ST_OPEN;
        end else begin
          tries_d = (tries_q != '0) ? tries_q - 1'b1 : '0;
          state_d = ST_FAIL;
        end
      end
      ST_OPEN: begin
        if (press) begin
          state_d = prog ? ST_PROG : ST_IDLE;
        end else if (OPEN_CYCLES > 0) begin
          if (timer_q == '0) state_d = ST_IDLE;
          else               timer_d = timer_q - 1'b1;
        end
      end
      ST_FAIL: begin
        if (timer_q == '0) state_d = (tries_q == '0) ? ST_LOCKOUT : ST_IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          tries_d = TRY_W'(MAX_TRIES);
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_PROG: begin
        if (press) begin
          entry_d = entry_wr;
          if (cnt_q == CNT_W'(N_DIGITS - 1)) begin
            code_d  = entry_wr;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state entry reloads the shared timer; IDLE, CHECK and PROG
    // also start with an empty digit count.
    if (state_d != state_q) begin
      case (state_d)
        ST_FAIL:    timer_d = FAIL_LD;
        ST_LOCKOUT: timer_d = LOCK_LD;
        ST_OPEN:    timer_d = OPEN_LD;
        default:    timer_d = '0;
      endcase
      if (state_d == ST_IDLE || state_d == ST_CHECK || state_d == ST_PROG) cnt_d = '0;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg7_decoder #(.DIGIT_W(DIGIT_W)) u_dec (
      .digit_i (entry_q[(N_DIGITS-1-g)*DIGIT_W +: DIGIT_W]),
      .seg_o   (glyph[g])
    );
  end

  // Output logic.
  always_comb begin
    unlocked   = (state_q == ST_OPEN) || (state_q == ST_PROG);
    alarm      = (state_q == ST_LOCKOUT);
    tries_left = tries_q;
    digit_cnt  = cnt_q;
    hex_out    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (state_q == ST_LOCKOUT)      hex_out[(N_DIGITS-1-i)*7 +: 7] = SEG_BLANK;
      else if (state_q == ST_IDLE)    hex_out[(N_DIGITS-1-i)*7 +: 7] = SEG_DASH;
      else if (CNT_W'(i) < cnt_q)     hex_out[(N_DIGITS-1-i)*7 +: 7] = glyph[i];
      else                            hex_out[(N_DIGITS-1-i)*7 +: 7] = SEG_DASH;
    end
  end

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Bench for password_lock_ctrl: a behavioural model steps on every rising
// clock and queues the outputs it expects; a monitor on the falling clock
// pops each expectation and compares it with the DUT.
module tb_password_lock_ctrl;

  localparam int N    = 4;
  localparam int MAXT = 3;
  localparam int FC   = 10;
  localparam int LC   = 50;
  localparam int OC   = 100;
  localparam logic [15:0] DEF = 16'h1234;
  localparam logic [6:0]  DASH = 7'b1111110;
  localparam logic [27:0] ALL_DASH = {4{DASH}};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        next = 1'b0;
  logic        prog = 1'b0;
  logic [3:0]  digit_in = 4'h0;
  logic        unlocked, alarm;
  logic [1:0]  tries_left;
  logic [2:0]  digit_cnt;
  logic [27:0] hex_out;

  always #5 clk = ~clk;

  password_lock_ctrl #(
    .N_DIGITS(N), .DIGIT_W(4), .DEFAULT_CODE(DEF), .MAX_TRIES(MAXT),
    .FAIL_CYCLES(FC), .LOCK_CYCLES(LC), .OPEN_CYCLES(OC)
  ) dut (
    .clk(clk), .rst(rst), .next(next), .prog(prog), .digit_in(digit_in),
    .unlocked(unlocked), .alarm(alarm), .tries_left(tries_left),
    .digit_cnt(digit_cnt), .hex_out(hex_out)
  );

  typedef struct packed {
    logic        ul;
    logic        al;
    logic [1:0]  tr;
    logic [2:0]  dc;
    logic [27:0] hx;
  } obs_t;

  obs_t expq[$];
  obs_t e_m, a_m, e_s;
  int   total = 0;
  int   bad   = 0;

  // Reference glyphs, active-low abcdefg.
  logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // ---------------- behavioural model ----------------
  string mode = "IDLE";
  int    ent[$];
  int    pent[$];
  int    code[N];
  int    tries  = MAXT;
  int    remain = 0;
  bit    prevn  = 1'b1;

  task automatic model_step();
    bit press, ok;
    if (!rst) begin
      mode = "IDLE";
      ent.delete();
      pent.delete();
      for (int i = 0; i < N; i++) code[i] = int'((DEF >> (4 * (N - 1 - i))) & 16'hF);
      tries  = MAXT;
      remain = 0;
      prevn  = 1'b1;
    end else begin
      press = next && !prevn;
      prevn = next;
      if (mode == "IDLE") begin
        if (press) begin
          ent.delete();
          ent.push_back(int'(digit_in));
          mode = (N == 1) ? "CHECK" : "ENTER";
        end
      end else if (mode == "ENTER") begin
        if (ent.size() == N) mode = "CHECK";
        else if (press) ent.push_back(int'(digit_in));
      end else if (mode == "CHECK") begin
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (ent[i] != code[i]) ok = 1'b0;
        if (ok) begin
          tries = MAXT; mode = "OPEN"; remain = OC;
        end else begin
          tries = tries - 1; mode = "REJECT"; remain = FC;
        end
      end else if (mode == "OPEN") begin
        if (press) begin
          if (prog) begin mode = "PROG"; pent.delete(); end
          else mode = "IDLE";
        end else if (OC > 0) begin
          remain = remain - 1;
          if (remain == 0) mode = "IDLE";
        end
      end else if (mode == "REJECT") begin
        remain = remain - 1;
        if (remain == 0) begin
          if (tries == 0) begin mode = "LOCKOUT"; remain = LC; end
          else mode = "IDLE";
        end
      end else if (mode == "LOCKOUT") begin
        remain = remain - 1;
        if (remain == 0) begin tries = MAXT; mode = "IDLE"; end
      end else if (mode == "PROG") begin
        if (press) begin
          pent.push_back(int'(digit_in));
          if (pent.size() == N) begin
            for (int i = 0; i < N; i++) code[i] = pent[i];
            mode = "IDLE";
          end
        end
      end
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int   cnt, d;
    cnt  = (mode == "ENTER") ? ent.size() : (mode == "PROG") ? pent.size() : 0;
    o.ul = (mode == "OPEN") || (mode == "PROG");
    o.al = (mode == "LOCKOUT");
    o.tr = 2'(tries);
    o.dc = 3'(cnt);
    o.hx = '0;
    for (int i = 0; i < N; i++) begin
      if (mode == "LOCKOUT")   o.hx[(N-1-i)*7 +: 7] = 7'h7F;
      else if (mode == "IDLE") o.hx[(N-1-i)*7 +: 7] = DASH;
      else if (i < cnt) begin
        d = (mode == "ENTER") ? ent[i] : pent[i];
        o.hx[(N-1-i)*7 +: 7] = glyph[d];
      end else                 o.hx[(N-1-i)*7 +: 7] = DASH;
    end
    return o;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
    e_s = model_out();
    expq.push_back(e_s);
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (expq.size() > 0) begin
      e_m  = expq.pop_front();
      a_m  = '{ul: unlocked, al: alarm, tr: tries_left, dc: digit_cnt, hx: hex_out};
      total++;
      if (a_m !== e_m) begin
        bad++;
        $display("FAIL outputs t=%0t got ul=%b al=%b tries=%0d cnt=%0d hex=%h want ul=%b al=%b tries=%0d cnt=%0d hex=%h",
                 $time, a_m.ul, a_m.al, a_m.tr, a_m.dc, a_m.hx, e_m.ul, e_m.al, e_m.tr, e_m.dc, e_m.hx);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic [3:0] d, input bit pg);
    digit_in = d; prog = pg; next = 1'b1;
    step(2);
    next = 1'b0; prog = 1'b0;
    step(2);
  endtask

  task automatic entry(input logic [15:0] c);
    for (int i = 0; i < N; i++) press(c[15-4*i -: 4], 1'b0);
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (unlocked !== 1'b0 || alarm !== 1'b0 || digit_cnt !== 3'd0 ||
        tries_left !== 2'(MAXT) || hex_out !== ALL_DASH) begin
      bad++;
      $display("FAIL async_reset got ul=%b al=%b tries=%0d cnt=%0d hex=%h want ul=0 al=0 tries=%0d cnt=0 hex=%h",
               unlocked, alarm, tries_left, digit_cnt, hex_out, MAXT, ALL_DASH);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int op, k;
    // Button held through reset release must not count as a press.
    next = 1'b1;
    step(3);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    step(3);
    next = 1'b0;
    step(2);

    // Correct code opens, then a plain press closes.
    entry(16'h1234);
    step(2);
    press(4'h0, 1'b0);
    step(3);

    // Three wrong entries lead to lockout; presses during lockout are ignored.
    repeat (3) begin entry(16'h1235); step(FC + 3); end
    repeat (3) press(4'h5, 1'b0);
    step(LC);

    // Reprogram to 9876; old code rejected, new one accepted.
    entry(16'h1234);
    press(4'h0, 1'b1);
    entry(16'h9876);
    step(2);
    entry(16'h1234);
    step(FC + 3);
    entry(16'h9876);
    step(2);
    press(4'h0, 1'b0);
    step(2);

    // Auto-relock after OPEN_CYCLES with no press.
    entry(16'h9876);
    step(OC + 10);

    // Held button yields a single press.
    digit_in = 4'h7; next = 1'b1;
    step(20);
    next = 1'b0;
    step(2);

    // Reset in ENTER with two digits, then during lockout; code reverts.
    press(4'h3, 1'b0);
    do_reset();
    step(2);
    repeat (3) begin entry(16'hABCD); step(FC + 3); end
    step(10);
    do_reset();
    step(2);
    entry(16'h1234);
    step(3);
    press(4'h0, 1'b0);
    step(2);

    // Randomised traffic, biased toward the model's current code.
    k = 0;
    repeat (300) begin
      op = int'($urandom_range(0, 99));
      if (op < 60) begin
        if ($urandom_range(0, 3) != 0) digit_in = 4'(code[k % N]);
        else                           digit_in = 4'($urandom_range(0, 15));
        k++;
        prog = ($urandom_range(0, 7) == 0);
        next = 1'b1;
        step(int'($urandom_range(1, 3)));
        next = 1'b0; prog = 1'b0;
        step(int'($urandom_range(1, 3)));
      end else if (op < 90) begin
        step(int'($urandom_range(0, 20)));
      end else if (op < 98) begin
        step(60);
      end else begin
        do_reset();
        k = 0;
      end
    end

    step(3);
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/password_lock_ctrl.md
PASSWORD_LOCK_CTRL -- requirements
Module: password_lock_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4: number of code digits, range 1..8.
REQ-002 Parameter DIGIT_W, default 4: bits per digit.
REQ-003 Parameter DEFAULT_CODE, default 16'h1234: reset code, N_DIGITS*DIGIT_W bits, digit 0 in the MS field.
REQ-004 Parameter MAX_TRIES, default 3: failed attempts allowed before lockout.
REQ-005 Parameter FAIL_CYCLES, default 10: cycles the FAIL state is held.
REQ-006 Parameter LOCK_CYCLES, default 50: cycles the LOCKOUT state is held.
REQ-007 Parameter OPEN_CYCLES, default 100: cycles OPEN is held before auto-relock; 0 disables auto-relock.
REQ-008 clk  input  1  block clock, the divided 5 Hz clock in the board build.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 next  input  1  active-high enter button, level; only its rising edge is used.
REQ-011 prog  input  1  program-mode request, sampled on a next edge while OPEN.
REQ-012 digit_in  input  DIGIT_W  digit presented on the switches.
REQ-013 unlocked  output  1  high in OPEN and PROG.
REQ-014 alarm  output  1  high in LOCKOUT.
REQ-015 tries_left  output  $clog2(MAX_TRIES+1)  remaining attempts.
REQ-016 digit_cnt  output  $clog2(N_DIGITS+1)  digits captured in the current entry.
REQ-017 hex_out  output  N_DIGITS*7  active-low segments, 7 bits per digit in abcdefg order, digit 0 in the MS field.

Function
REQ-018 A press is a rising edge of next, detected by a 1-cycle registered compare; holding next produces one press.
REQ-019 States: IDLE, ENTER, CHECK, OPEN, FAIL, LOCKOUT, PROG.
REQ-020 IDLE: on a press, capture digit_in into slot 0, set digit_cnt=1, and go to ENTER (or CHECK/PROG-complete if N_DIGITS=1).
REQ-021 ENTER: each press stores digit_in in slot digit_cnt and increments digit_cnt; the press that fills slot N_DIGITS-1 moves to CHECK on the next edge.
REQ-022 CHECK lasts 1 cycle: full-width compare of the entry with the code register; match goes to OPEN with tries_left=MAX_TRIES; mismatch decrements tries_left and goes to FAIL.
REQ-023 Unlock latency: unlocked rises 2 clk edges after the edge that captures the last digit.
REQ-024 FAIL holds FAIL_CYCLES cycles, then goes to LOCKOUT if tries_left=0, else to IDLE; presses in FAIL are ignored.
REQ-025 LOCKOUT holds LOCK_CYCLES cycles, ignores presses, then restores tries_left=MAX_TRIES and goes to IDLE.
REQ-026 OPEN: a press with prog=0 goes to IDLE; a press with prog=1 goes to PROG with digit_cnt=0; when OPEN_CYCLES>0, OPEN_CYCLES cycles without a press go to IDLE.
REQ-027 PROG: presses fill slots as in ENTER; the press filling the last slot writes the whole entry into the code register and goes to IDLE on the same edge.
REQ-028 digit_cnt clears on every entry to IDLE, CHECK and PROG.
REQ-029 hex_out shows the hex glyph for captured slots and '-' (7'b1111110) for uncaptured slots; it shows all '-' in IDLE and all segments off in LOCKOUT.
REQ-030 Digit values above 9 display as A-F.
REQ-031 The cycle timer is a single down-counter sized for max(FAIL_CYCLES, LOCK_CYCLES, OPEN_CYCLES), reloaded on each state entry.

Reset
REQ-032 Asserting rst low immediately, at any point in any state, forces IDLE with unlocked=0, alarm=0, tries_left=MAX_TRIES, digit_cnt=0, timer=0, entry cleared, hex_out all '-', and the code register set to DEFAULT_CODE.
REQ-033 A programmed code does not survive reset.
REQ-034 The release of rst is synchronised externally.
REQ-035 A next level already high at reset release does not count as a press.

Structure
REQ-036 The state encoding enum and the '-' and blank segment constants belong in the shared package.
REQ-037 Segment decoding is a sub-module, seg7_decoder: DIGIT_W hex digit in, 7-bit active-low segments out; instantiate one per digit with a generate loop.
REQ-038 The FSM, entry register, code register and timer are in password_lock_ctrl.

Verification
REQ-039 Reset, then presses with digit_in 1,2,3,4 -> CHECK, then unlocked=1 two edges after the fourth press, tries_left=3.
REQ-040 Entry 1,2,3,5 three times -> tries_left goes 2,1,0; after the third FAIL, alarm=1 for 50 cycles, presses are ignored, then IDLE with tries_left=3.
REQ-041 Unlock, press with prog=1, enter 9,8,7,6 -> IDLE; entry 1,2,3,4 fails; entry 9,8,7,6 opens.
REQ-042 Unlock and apply no press for 100 cycles -> unlocked falls and state is IDLE.
REQ-043 Hold next high for 20 cycles -> digit_cnt increments by exactly 1.
REQ-044 Assert rst after 2 digits in ENTER and again during LOCKOUT -> IDLE, digit_cnt=0, hex_out all '-', code is 16'h1234.
